// File: rtl/median_1xn_filter_if.sv
// Pixel stream bundle around the 1xN binary filter: camera sideband and pixel word in,
// delayed sideband, filtered word and debug ones count out.
interface median_1xn_filter_if #(
  parameter int DATA_W = 16,
  parameter int HCNT_W = 10,
  parameter int PCNT_W = 11,
  parameter int CNT_W  = 4
);
  logic              Cam_enable_in;
  logic [HCNT_W-1:0] CamHsync_count_in;
  logic [PCNT_W-1:0] CamPix_count_in;
  logic [DATA_W-1:0] data_in;

  logic              Cam_enable_out;
  logic [HCNT_W-1:0] CamHsync_count_out;
  logic [PCNT_W-1:0] CamPix_count_out;
  logic [DATA_W-1:0] data_out;
  logic [CNT_W-1:0]  ones_count_out;

  modport master (
    output Cam_enable_in, CamHsync_count_in, CamPix_count_in, data_in,
    input  Cam_enable_out, CamHsync_count_out, CamPix_count_out, data_out, ones_count_out
  );

  modport slave (
    input  Cam_enable_in, CamHsync_count_in, CamPix_count_in, data_in,
    output Cam_enable_out, CamHsync_count_out, CamPix_count_out, data_out, ones_count_out
  );
endinterface

// File: rtl/median_1xn_filter.sv
// 1xN binary erode/dilate/majority/threshold filter on one pixel bit, falling-edge pipeline.
// Latency (TAPS+1)/2 cycles; no backpressure, one result every clock.
module median_1xn_filter #(
  parameter int TAPS    = 9,
  parameter int BIT_SEL = 15,
  parameter int DATA_W  = 16,
  parameter int HCNT_W  = 10,
  parameter int PCNT_W  = 11,
  localparam int CNT_W  = $clog2(TAPS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] thresh,
  median_1xn_filter_if.slave bus
);

  localparam int L = (TAPS + 1) / 2;

  typedef struct packed {
    logic              en;
    logic [HCNT_W-1:0] hs;
    logic [PCNT_W-1:0] px;
  } side_t;

  // The live input is the newest tap, so window plus decision register total exactly L stages.
  logic [TAPS-2:0]  win_px;
  logic [TAPS-2:0]  win_en;
  logic [TAPS-1:0]  tap_px;
  logic [TAPS-1:0]  tap_en;
  logic [CNT_W-1:0] ones;
  logic [CNT_W-1:0] nvalid;
  logic [CNT_W:0]   twice_ones;
  logic             decide;
  logic             dec_q;
  logic [CNT_W-1:0] ones_q;
  side_t            side_in;
  side_t            side_q [L];

  assign tap_px = {win_px, bus.data_in[BIT_SEL]};
  assign tap_en = {win_en, bus.Cam_enable_in};

  assign side_in.en = bus.Cam_enable_in;
  assign side_in.hs = bus.CamHsync_count_in;
  assign side_in.px = bus.CamPix_count_in;

  always_comb begin
    ones   = '0;
    nvalid = '0;
    for (int i = 0; i < TAPS; i++) begin
      if (tap_en[i]) begin
        nvalid = nvalid + CNT_W'(1);
        if (tap_px[i]) ones = ones + CNT_W'(1);
      end
    end
  end

  assign twice_ones = {ones, 1'b0};

  // Invalid taps are left out of nvalid, so erosion at a line edge only looks at real pixels.
  always_comb begin
    decide = 1'b0;
    case (mode)
      2'd0:    decide = (nvalid != '0) && (ones == nvalid);
      2'd1:    decide = (ones != '0);
      2'd2:    decide = (twice_ones > {1'b0, nvalid});
      default: decide = (ones >= thresh);
    endcase
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      win_px <= '0;
      win_en <= '0;
      dec_q  <= 1'b0;
      ones_q <= '0;
      for (int i = 0; i < L; i++) side_q[i] <= '0;
    end else begin
      win_px    <= tap_px[TAPS-2:0];
      win_en    <= tap_en[TAPS-2:0];
      dec_q     <= decide;
      ones_q    <= ones;
      side_q[0] <= side_in;
      for (int i = 1; i < L; i++) side_q[i] <= side_q[i-1];
    end
  end

  assign bus.Cam_enable_out     = side_q[L-1].en;
  assign bus.CamHsync_count_out = side_q[L-1].hs;
  assign bus.CamPix_count_out   = side_q[L-1].px;
  assign bus.data_out           = (dec_q && side_q[L-1].en) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
  assign bus.ones_count_out     = ones_q;

endmodule

// File: tb/tb_median_1xn_filter.sv
// Scoreboard bench for median_1xn_filter (TAPS=9, L=5): a per-cycle input history model
// predicts each registered output, which is queued and compared when the DUT presents it.
module tb_median_1xn_filter;

  localparam int TAPS    = 9;
  localparam int L       = 5;
  localparam int BIT_SEL = 15;
  localparam int DATA_W  = 16;
  localparam int HCNT_W  = 10;
  localparam int PCNT_W  = 11;
  localparam int CNT_W   = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       mode;
  logic [CNT_W-1:0] thresh;

  median_1xn_filter_if #(.DATA_W(DATA_W), .HCNT_W(HCNT_W), .PCNT_W(PCNT_W), .CNT_W(CNT_W)) bus ();

  median_1xn_filter #(
    .TAPS(TAPS), .BIT_SEL(BIT_SEL), .DATA_W(DATA_W), .HCNT_W(HCNT_W), .PCNT_W(PCNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mode(mode),
    .thresh(thresh),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] dat;
    logic              en;
    logic [HCNT_W-1:0] hs;
    logic [PCNT_W-1:0] pc;
    logic [CNT_W-1:0]  ones;
  } exp_t;

  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rst = -1;
  int ffff_cnt = 0;
  int line2_cnt = 0;
  int watch_zeros = 0;
  logic watch = 1'b0;

  logic              h_en [0:4095];
  logic              h_px [0:4095];
  logic [HCNT_W-1:0] h_hs [0:4095];
  logic [PCNT_W-1:0] h_pc [0:4095];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // One clock: compare the output of the previous falling edge, drive new inputs, predict next output.
  task automatic step(input logic r, input logic en, input logic b,
                      input logic [HCNT_W-1:0] hs, input logic [PCNT_W-1:0] pc);
    exp_t e;
    logic [DATA_W-1:0] w;
    int ones;
    int nv;
    int s;
    logic dec;
    @(posedge clk);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check_eq("data_out", 32'(bus.data_out), 32'(e.dat));
      check_eq("sideband", 32'({bus.Cam_enable_out, bus.CamHsync_count_out, bus.CamPix_count_out}),
               32'({e.en, e.hs, e.pc}));
      check_eq("ones_count", 32'(bus.ones_count_out), 32'(e.ones));
      if (bus.data_out == 16'hffff) begin
        ffff_cnt++;
        if (bus.Cam_enable_out && bus.CamHsync_count_out == 10'd2) line2_cnt++;
      end
      if (watch) begin
        if (bus.Cam_enable_out) begin
          check_eq("first_valid_delay", 32'(watch_zeros), 32'(L));
          check_eq("first_valid_ones", 32'(bus.ones_count_out), 32'd5);
          watch = 1'b0;
        end else begin
          watch_zeros++;
        end
      end
    end

    w = DATA_W'($urandom);
    w[BIT_SEL] = b;
    reset = r;
    bus.Cam_enable_in     = en;
    bus.CamHsync_count_in = hs;
    bus.CamPix_count_in   = pc;
    bus.data_in           = w;

    if (r) last_rst = cyc;
    h_en[cyc] = en;
    h_px[cyc] = b;
    h_hs[cyc] = hs;
    h_pc[cyc] = pc;

    e = '0;
    if (!r) begin
      ones = 0;
      nv = 0;
      for (int j = cyc - TAPS + 1; j <= cyc; j++) begin
        if (j > last_rst && h_en[j]) begin
          nv++;
          if (h_px[j]) ones++;
        end
      end
      case (mode)
        2'd0:    dec = (nv > 0) && (ones == nv);
        2'd1:    dec = (ones > 0);
        2'd2:    dec = (2 * ones > nv);
        default: dec = (ones >= int'(thresh));
      endcase
      s = cyc + 1 - L;
      if (s > last_rst) begin
        e.en = h_en[s];
        e.hs = h_hs[s];
        e.pc = h_pc[s];
      end
      e.ones = CNT_W'(ones);
      e.dat  = (dec && e.en) ? 16'hffff : 16'h0000;
    end
    sb_q.push_back(e);
    cyc++;

    if (r) begin
      #1;
      check_eq("reset_data_ones", 32'({bus.data_out, bus.ones_count_out}), 32'd0);
      check_eq("reset_sideband", 32'({bus.Cam_enable_out, bus.CamHsync_count_out, bus.CamPix_count_out}),
               32'd0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    reset = 1'b1;
    mode = 2'd0;
    thresh = '0;
    bus.Cam_enable_in = 1'b0;
    bus.CamHsync_count_in = '0;
    bus.CamPix_count_in = '0;
    bus.data_in = '0;

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, '0, '0);
    idle(12);

    // Erode: a 20-pixel run of ones survives whole, including its edges.
    mode = 2'd0;
    ffff_cnt = 0;
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1, 10'd1, PCNT_W'(i));
    idle(12);
    check_eq("erode_ffff_count", 32'(ffff_cnt), 32'd20);

    // Dilate: a single one at pixel 10 spreads over pixels 6..14.
    mode = 2'd1;
    ffff_cnt = 0;
    for (int i = 0; i < 21; i++) step(1'b0, 1'b1, (i == 10), 10'd1, PCNT_W'(i));
    idle(12);
    check_eq("dilate_ffff_count", 32'(ffff_cnt), 32'd9);

    // Majority over a repeating 111110000 pattern.
    mode = 2'd2;
    for (int i = 0; i < 27; i++) step(1'b0, 1'b1, ((i % 9) < 5), 10'd2, PCNT_W'(i));
    idle(12);

    // Threshold 3 with three ones at pixels 5..7: centres 3..9 see all three.
    mode = 2'd3;
    thresh = 4'd3;
    ffff_cnt = 0;
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, (i >= 5 && i <= 7), 10'd4, PCNT_W'(i));
    idle(12);
    check_eq("thresh3_ffff_count", 32'(ffff_cnt), 32'd7);

    thresh = 4'd0;
    ffff_cnt = 0;
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b0, 10'd5, PCNT_W'(i));
    idle(12);
    check_eq("thresh0_ffff_count", 32'(ffff_cnt), 32'd15);

    // Reset for two cycles in the middle of a run of ones.
    mode = 2'd1;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, 10'd6, PCNT_W'(i));
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b1, 10'd6, PCNT_W'(10 + i));
    watch = 1'b1;
    watch_zeros = 0;
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b1, 10'd6, PCNT_W'(12 + i));
    idle(12);
    check_eq("first_valid_seen", 32'(watch), 32'd0);

    // Two lines split by a 3-cycle gap; line 2 is all zeros and must stay zero under dilation.
    mode = 2'd1;
    line2_cnt = 0;
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, (i != 11), 10'd1, PCNT_W'(i));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0, 10'd2, PCNT_W'(i));
    idle(12);
    check_eq("line2_ffff_count", 32'(line2_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
